// File: rtl/serial_comparator_pkg.sv
// Shared constants for the serial comparator: FSM state encoding and operand geometry.
// Optional feature macro used by the top: SERIAL_COMPARATOR_SIGNED_EN.
package serial_comparator_pkg;

  localparam int OPERAND_W  = 32;
  localparam int BYTE_W     = 8;
  localparam int BYTE_COUNT = 4;
  localparam int IDX_W      = $clog2(BYTE_COUNT);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COMPARE = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(BYTE_COUNT - 1);

endpackage

// File: rtl/serial_comparator_byte_compare.sv
// Combinational unsigned comparison of one byte pair; the top reuses a single
// instance for every byte position through a select multiplexer.
module byte_compare
  import serial_comparator_pkg::*;
(
  input  logic [BYTE_W-1:0] a_i,
  input  logic [BYTE_W-1:0] b_i,
  output logic              eq_o,
  output logic              lt_o
);

  assign eq_o = (a_i == b_i);
  assign lt_o = (a_i < b_i);

endmodule

// File: rtl/serial_comparator.sv
// Byte-serial 32-bit magnitude comparator, MSB byte first with early exit.
// Define SERIAL_COMPARATOR_SIGNED_EN to honour signed_mode (two's-complement order).
module serial_comparator
  import serial_comparator_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [OPERAND_W-1:0] a,
  input  logic [OPERAND_W-1:0] b,
  input  logic                 signed_mode,
  output logic                 ready,
  output logic                 done,
  output logic                 is_equal,
  output logic                 is_not_equal,
  output logic                 is_less_than
);

  logic [1:0]           state_q, state_d;
  logic [OPERAND_W-1:0] aOp_q, aOp_d;
  logic [OPERAND_W-1:0] bOp_q, bOp_d;
  logic                 signed_q, signed_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 eq_q, eq_d;
  logic                 neq_q, neq_d;
  logic                 lt_q, lt_d;

  logic [BYTE_W-1:0]    byteA, byteB;
  logic [BYTE_W-1:0]    cmpA, cmpB;
  logic                 flipMsb;
  logic                 byteEq, byteLt;

  // Flipping the sign bit of the top byte maps two's-complement order onto unsigned order.
`ifdef SERIAL_COMPARATOR_SIGNED_EN
  assign flipMsb = signed_q && (idx_q == TOP_IDX);
`else
  logic unusedSignedMode;
  assign flipMsb          = 1'b0;
  assign unusedSignedMode = signed_q;
`endif

  always_comb begin
    byteA = aOp_q[idx_q*BYTE_W +: BYTE_W];
    byteB = bOp_q[idx_q*BYTE_W +: BYTE_W];
    cmpA  = {byteA[BYTE_W-1] ^ flipMsb, byteA[BYTE_W-2:0]};
    cmpB  = {byteB[BYTE_W-1] ^ flipMsb, byteB[BYTE_W-2:0]};
  end

  byte_compare u_byte_compare (
    .a_i  (cmpA),
    .b_i  (cmpB),
    .eq_o (byteEq),
    .lt_o (byteLt)
  );

  always_comb begin
    state_d  = state_q;
    aOp_d    = aOp_q;
    bOp_d    = bOp_q;
    signed_d = signed_q;
    idx_d    = idx_q;
    eq_d     = eq_q;
    neq_d    = neq_q;
    lt_d     = lt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          aOp_d    = a;
          bOp_d    = b;
          signed_d = signed_mode;
          idx_d    = TOP_IDX;
          eq_d     = 1'b0;
          neq_d    = 1'b0;
          lt_d     = 1'b0;
          state_d  = COMPARE;
        end
      end
      COMPARE: begin
        // First differing byte decides the ordering; lower bytes cannot change it.
        if (!byteEq) begin
          eq_d    = 1'b0;
          neq_d   = 1'b1;
          lt_d    = byteLt;
          state_d = DONE;
        end else if (idx_q == '0) begin
          eq_d    = 1'b1;
          neq_d   = 1'b0;
          lt_d    = 1'b0;
          state_d = DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      DONE: begin
        idx_d   = TOP_IDX;
        state_d = IDLE;
      end
      default: begin
        idx_d   = TOP_IDX;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      aOp_q    <= '0;
      bOp_q    <= '0;
      signed_q <= 1'b0;
      idx_q    <= TOP_IDX;
      eq_q     <= 1'b0;
      neq_q    <= 1'b0;
      lt_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      aOp_q    <= aOp_d;
      bOp_q    <= bOp_d;
      signed_q <= signed_d;
      idx_q    <= idx_d;
      eq_q     <= eq_d;
      neq_q    <= neq_d;
      lt_q     <= lt_d;
    end
  end

  assign ready        = (state_q == IDLE);
  assign done         = (state_q == DONE);
  assign is_equal     = eq_q;
  assign is_not_equal = neq_q;
  assign is_less_than = lt_q;

endmodule

// File: tb/tb_serial_comparator.sv
// Directed self-checking bench for serial_comparator; expected latencies and flags are hand-computed.
// Signed expectations follow SERIAL_COMPARATOR_SIGNED_EN as defined for the build.
module tb_serial_comparator;

  logic        clock;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        signed_mode;
  logic        ready;
  logic        done;
  logic        is_equal;
  logic        is_not_equal;
  logic        is_less_than;

  int checks   = 0;
  int failures = 0;

  serial_comparator dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .a            (a),
    .b            (b),
    .signed_mode  (signed_mode),
    .ready        (ready),
    .done         (done),
    .is_equal     (is_equal),
    .is_not_equal (is_not_equal),
    .is_less_than (is_less_than)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Presents one request, then counts negedges after the accepting edge until done is seen.
  // lat stays 0 if done never appears within the bound.
  task automatic runCompare(input logic [31:0] av, input logic [31:0] bv,
                            input logic sm, output int lat);
    int n;
    @(negedge clock);
    a = av;
    b = bv;
    signed_mode = sm;
    start = 1'b1;
    lat = 0;
    n = 0;
    while (lat == 0 && n < 20) begin
      @(negedge clock);
      start = 1'b0;
      n++;
      if (done) lat = n;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    signed_mode = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if ({ready, done} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL reset_ready_done got=%b exp=10", {ready, done});
    end
    checks++;
    if ({is_equal, is_not_equal, is_less_than} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL reset_flags got=%b exp=000", {is_equal, is_not_equal, is_less_than});
    end
    // reset and start together: reset must win, so the FSM stays idle
    a = 32'h1;
    b = 32'h2;
    start = 1'b1;
    @(negedge clock);
    checks++;
    if (ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_beats_start ready got=%b exp=1", ready);
    end
    reset = 1'b0;
    start = 1'b0;
    @(negedge clock);
    checks++;
    if ({ready, done} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL after_reset_idle got=%b exp=10", {ready, done});
    end
  endtask

  task automatic test_equal;
    int lat;
    runCompare(32'h12345678, 32'h12345678, 1'b0, lat);
    checks++;
    if (lat !== 5) begin
      failures++;
      $display("[TB] FAIL equal_latency got=%0d exp=5", lat);
    end
    checks++;
    if ({is_equal, is_not_equal, is_less_than} !== 3'b100) begin
      failures++;
      $display("[TB] FAIL equal_flags got=%b exp=100", {is_equal, is_not_equal, is_less_than});
    end
    checks++;
    if (ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ready_in_done got=%b exp=0", ready);
    end
    @(negedge clock);
    checks++;
    if ({ready, done, is_equal, is_not_equal, is_less_than} !== 5'b10100) begin
      failures++;
      $display("[TB] FAIL equal_hold got=%b exp=10100",
               {ready, done, is_equal, is_not_equal, is_less_than});
    end
  endtask

  task automatic test_byte_diffs;
    logic [31:0] av [5] = '{32'h01000000, 32'h00010000, 32'h00000300, 32'h00000005, 32'h00000004};
    logic [31:0] bv [5] = '{32'h02000000, 32'h00020000, 32'h00000200, 32'h00000004, 32'h00000005};
    int          expLat [5] = '{2, 3, 4, 5, 5};
    logic [2:0]  expFlags [5] = '{3'b011, 3'b011, 3'b010, 3'b010, 3'b011};
    int lat;
    for (int i = 0; i < 5; i++) begin
      runCompare(av[i], bv[i], 1'b0, lat);
      checks++;
      if (lat !== expLat[i]) begin
        failures++;
        $display("[TB] FAIL diff%0d_latency got=%0d exp=%0d", i, lat, expLat[i]);
      end
      checks++;
      if ({is_equal, is_not_equal, is_less_than} !== expFlags[i]) begin
        failures++;
        $display("[TB] FAIL diff%0d_flags got=%b exp=%b", i,
                 {is_equal, is_not_equal, is_less_than}, expFlags[i]);
      end
    end
  endtask

  task automatic test_signed;
    int lat;
    logic expLt;
`ifdef SERIAL_COMPARATOR_SIGNED_EN
    expLt = 1'b1;
`else
    expLt = 1'b0;
`endif
    runCompare(32'hFFFFFFFF, 32'h00000001, 1'b1, lat);
    checks++;
    if (lat !== 2) begin
      failures++;
      $display("[TB] FAIL signed_latency got=%0d exp=2", lat);
    end
    checks++;
    if ({is_equal, is_not_equal, is_less_than} !== {2'b01, expLt}) begin
      failures++;
      $display("[TB] FAIL signed_flags got=%b exp=%b",
               {is_equal, is_not_equal, is_less_than}, {2'b01, expLt});
    end
    runCompare(32'hFFFFFFFF, 32'h00000001, 1'b0, lat);
    checks++;
    if ({lat == 2, is_equal, is_not_equal, is_less_than} !== 4'b1010) begin
      failures++;
      $display("[TB] FAIL unsigned_mode_flags got=lat%0d/%b exp=lat2/010",
               lat, {is_equal, is_not_equal, is_less_than});
    end
  endtask

  task automatic test_reset_mid_compare;
    logic sawDone;
    @(negedge clock);
    a = 32'hAAAAAAAA;
    b = 32'hAAAAAAAA;
    signed_mode = 1'b0;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    checks++;
    if ({ready, is_equal, is_not_equal, is_less_than} !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL accept_clears_flags got=%b exp=0000",
               {ready, is_equal, is_not_equal, is_less_than});
    end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checks++;
    if ({ready, done, is_equal, is_not_equal, is_less_than} !== 5'b10000) begin
      failures++;
      $display("[TB] FAIL mid_reset_state got=%b exp=10000",
               {ready, done, is_equal, is_not_equal, is_less_than});
    end
    sawDone = 1'b0;
    repeat (6) begin
      @(negedge clock);
      if (done) sawDone = 1'b1;
    end
    checks++;
    if (sawDone !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mid_reset_no_done got=%b exp=0", sawDone);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clock);
    a = 32'h10000000;
    b = 32'h20000000;
    signed_mode = 1'b0;
    start = 1'b1;
    @(negedge clock);
    a = 32'h30000000;
    checks++;
    if (ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL b2b_first_accept ready got=%b exp=0", ready);
    end
    @(negedge clock);
    checks++;
    if ({done, is_equal, is_not_equal, is_less_than} !== 4'b1011) begin
      failures++;
      $display("[TB] FAIL b2b_first_result got=%b exp=1011",
               {done, is_equal, is_not_equal, is_less_than});
    end
    @(negedge clock);
    checks++;
    if ({ready, done, is_equal, is_not_equal, is_less_than} !== 5'b10011) begin
      failures++;
      $display("[TB] FAIL b2b_idle_hold got=%b exp=10011",
               {ready, done, is_equal, is_not_equal, is_less_than});
    end
    @(negedge clock);
    checks++;
    if ({ready, is_equal, is_not_equal, is_less_than} !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL b2b_second_accept got=%b exp=0000",
               {ready, is_equal, is_not_equal, is_less_than});
    end
    @(negedge clock);
    checks++;
    if ({done, is_equal, is_not_equal, is_less_than} !== 4'b1010) begin
      failures++;
      $display("[TB] FAIL b2b_second_result got=%b exp=1010",
               {done, is_equal, is_not_equal, is_less_than});
    end
    start = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if ({ready, done} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL b2b_not_queued got=%b exp=10", {ready, done});
    end
  endtask

  initial begin
    $display("[TB] serial_comparator directed tests");
    test_reset;
    test_equal;
    test_byte_diffs;
    test_signed;
    test_reset_mid_compare;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case a task ever stalls on the clock.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
